// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver.
//  - SEG_OFF: active-high "all segments dark" pattern.
//  - hex_to_seg(): 4-bit value to {g,f,e,d,c,b,a} pattern, hex glyphs 0-F.
//  - seg_pol(): applies the board polarity to an active-high segment pattern.
package seg7_scan_driver_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h00;

    function automatic seg_t hex_to_seg(input nibble_t v);
        seg_t s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    function automatic seg_t seg_pol(input seg_t s, input bit active_low);
        return active_low ? ~s : s;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the counter side and the 7-segment scan driver.
//  master: drives load/din/dp_mask/blank_lz, observes the display pins.
//  slave : the scan driver; consumes the load bus, drives seg/dp/an/frame_done.
interface seg7_scan_driver_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   din;
    logic                  blank_lz;
    logic [DIGITS-1:0]     dp_mask;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;
    logic                  frame_done;

    modport master (
        output load, din, blank_lz, dp_mask,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  load, din, blank_lz, dp_mask,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver_hex_decode.sv
// Combinational hex-to-7-segment decoder (active-high).
//  nibble_i : value 0-F
//  seg_o    : {g,f,e,d,c,b,a}
module seg7_scan_driver_hex_decode
    import seg7_scan_driver_pkg::*;
(
    input  nibble_t nibble_i,
    output seg_t    seg_o
);
    assign seg_o = hex_to_seg(nibble_i);
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver.
//  clk, rst : clock and asynchronous active-high reset
//  bus      : slave side of seg7_scan_driver_if
//             load/din/dp_mask capture a new value (shown from the next frame boundary),
//             blank_lz enables leading-zero suppression (sampled live),
//             seg/dp/an drive the display, frame_done pulses in the last cycle of a frame.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_CYC   = 64,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_driver_if.slave bus
);
    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DW = 5 * DIGITS;  // {dp_mask, din}

    localparam logic [DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic              DP_OFF  = ACTIVE_LOW;
    localparam seg_t              SEG_IDLE = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     pend_q, pend_d;
    logic [DW-1:0]     disp_q, disp_d;
    logic              pend_valid_q, pend_valid_d;
    logic [DIGITS-1:0] an_q, an_d;
    seg_t              seg_q, seg_d;
    logic              dp_q, dp_d;

    logic              tc, last_slot, wrap;
    logic [DIGITS-1:0] dp_bits, an_sel;
    logic [DIGITS:0]   lz;
    logic              blanked;
    nibble_t           cur_nibble;
    seg_t              cur_seg;

    assign tc        = (presc_q == PW'(REFRESH_DIV - 1));
    assign last_slot = (idx_q == IW'(DIGITS - 1));
    assign wrap      = tc & last_slot;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_q       <= '0;
            disp_q       <= '0;
            pend_valid_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_IDLE;
            dp_q         <= DP_OFF;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            disp_q       <= disp_d;
            pend_valid_q <= pend_valid_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    // Scan counters and load/transfer
    always_comb begin
        presc_d      = tc ? '0 : presc_q + 1'b1;
        idx_d        = idx_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        disp_d       = disp_q;
        if (tc) begin
            idx_d = last_slot ? '0 : idx_q + 1'b1;
        end
        if (wrap) begin
            // A load coinciding with the frame boundary bypasses the pending register.
            if (bus.load) begin
                disp_d = {bus.dp_mask, bus.din};
            end else if (pend_valid_q) begin
                disp_d = pend_q;
            end
            pend_valid_d = 1'b0;
        end else if (bus.load) begin
            pend_d       = {bus.dp_mask, bus.din};
            pend_valid_d = 1'b1;
        end
    end

    // lz[k] is set when nibbles DIGITS-1..k of disp are all zero.
    always_comb begin
        lz         = '0;
        lz[DIGITS] = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lz[k] = lz[k+1] & (disp_q[4*k +: 4] == 4'h0);
        end
    end

    assign dp_bits    = disp_q[DW-1 -: DIGITS];
    assign cur_nibble = disp_q[{idx_q, 2'b00} +: 4];
    assign blanked    = bus.blank_lz & (idx_q != '0) & lz[idx_q];

    seg7_scan_driver_hex_decode u_hex_decode (
        .nibble_i (cur_nibble),
        .seg_o    (cur_seg)
    );

    // Output next-state; internal logic is active-high, polarity applied last.
    always_comb begin
        an_sel        = '0;
        an_sel[idx_q] = 1'b1;
        an_d          = ((presc_q >= PW'(BLANK_CYC)) && !blanked) ? an_sel : '0;
        seg_d         = blanked ? SEG_OFF : cur_seg;
        dp_d          = !blanked & dp_bits[idx_q];
        if (ACTIVE_LOW) begin
            an_d = ~an_d;
            dp_d = ~dp_d;
        end
        seg_d = seg_pol(seg_d, ACTIVE_LOW);
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = wrap;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: two drivers (active-high and active-low) share one stimulus stream;
// each cycle both are compared against hand-computed slot/segment expectations.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] din;
    logic        blank_lz;
    logic [3:0]  dp_mask;

    int checks = 0;
    int errors = 0;
    int n      = 0;  // posedges since reset release == current scan state index

    int          ld_pos[3];
    logic [15:0] ld_din[3];
    logic [3:0]  ld_dpm[3];

    seg7_scan_driver_if #(.DIGITS(4)) bus0 ();
    seg7_scan_driver_if #(.DIGITS(4)) bus1 ();

    assign bus0.load = load;      assign bus1.load = load;
    assign bus0.din = din;        assign bus1.din = din;
    assign bus0.blank_lz = blank_lz; assign bus1.blank_lz = blank_lz;
    assign bus0.dp_mask = dp_mask; assign bus1.dp_mask = dp_mask;

    seg7_scan_driver #(
        .DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1), .ACTIVE_LOW(1'b0)
    ) u_dut_hi (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    seg7_scan_driver #(
        .DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1), .ACTIVE_LOW(1'b1)
    ) u_dut_lo (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    function automatic logic [27:0] segs4(input logic [6:0] s3, input logic [6:0] s2,
                                          input logic [6:0] s1, input logic [6:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    // Outputs after tick n reflect scan state n-1.
    task automatic tick_check(input logic [27:0] segs, input logic [3:0] dps,
                              input logic [3:0] vis);
        int s, slot, pr;
        logic [3:0] ea;
        logic [6:0] es;
        logic ed, ef;
        tick();
        s    = n - 1;
        slot = (s / 4) % 4;
        pr   = s % 4;
        ea   = (pr >= 1 && vis[slot]) ? 4'(1 << slot) : 4'b0000;
        es   = vis[slot] ? segs[slot*7 +: 7] : 7'h00;
        ed   = vis[slot] & dps[slot];
        ef   = (n % 16 == 15);
        check("act_hi", {3'b0, bus0.an, bus0.seg, bus0.dp, bus0.frame_done},
              {3'b0, ea, es, ed, ef});
        check("act_lo", {3'b0, bus1.an, bus1.seg, bus1.dp, bus1.frame_done},
              {3'b0, ~ea, ~es, ~ed, ef});
    endtask

    task automatic clear_loads();
        for (int j = 0; j < 3; j++) begin
            ld_pos[j] = -1;
            ld_din[j] = '0;
            ld_dpm[j] = '0;
        end
    endtask

    task automatic drive_loads(input int i);
        for (int j = 0; j < 3; j++) begin
            if (ld_pos[j] == i) begin
                load    = 1'b1;
                din     = ld_din[j];
                dp_mask = ld_dpm[j];
            end
        end
    endtask

    // One 16-cycle frame, starting with n%16 == 0.
    task automatic run_frame(input logic [27:0] segs, input logic [3:0] dps,
                             input logic [3:0] vis);
        for (int i = 0; i < 16; i++) begin
            drive_loads(i);
            tick_check(segs, dps, vis);
            load = 1'b0;
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_hi"}, {3'b0, bus0.an, bus0.seg, bus0.dp, bus0.frame_done}, 16'h0000);
        check({tag, "_lo"}, {3'b0, bus1.an, bus1.seg, bus1.dp, bus1.frame_done},
              {3'b0, 4'hF, 7'h7F, 1'b1, 1'b0});
    endtask

    initial begin
        logic [27:0] zeros, v12af, v0050, v3333;
        zeros = segs4(7'h3F, 7'h3F, 7'h3F, 7'h3F);
        v12af = segs4(7'h06, 7'h5B, 7'h77, 7'h71);
        v0050 = segs4(7'h3F, 7'h3F, 7'h6D, 7'h3F);
        v3333 = segs4(7'h4F, 7'h4F, 7'h4F, 7'h4F);

        rst      = 1'b1;
        load     = 1'b0;
        din      = '0;
        blank_lz = 1'b0;
        dp_mask  = '0;
        clear_loads();
        #12;
        check_dark("reset");
        @(negedge clk);
        rst = 1'b0;
        n   = 0;
        #1;
        check_dark("released");

        // 1: idle scan of 0000
        run_frame(zeros, 4'b0000, 4'b1111);
        run_frame(zeros, 4'b0000, 4'b1111);

        // 2: mid-frame load, old value held until the wrap
        ld_pos[0] = 5; ld_din[0] = 16'h12AF; ld_dpm[0] = 4'b0100;
        run_frame(zeros, 4'b0000, 4'b1111);
        clear_loads();
        run_frame(v12af, 4'b0100, 4'b1111);

        // 3: leading-zero blanking of 0050
        blank_lz  = 1'b1;
        ld_pos[0] = 3; ld_din[0] = 16'h0050; ld_dpm[0] = 4'b0000;
        run_frame(v12af, 4'b0100, 4'b1111);
        clear_loads();
        run_frame(v0050, 4'b0000, 4'b0011);

        // 4: last load wins; load in the wrap cycle bypasses pend
        blank_lz  = 1'b0;
        ld_pos[0] = 2;  ld_din[0] = 16'h1111;
        ld_pos[1] = 8;  ld_din[1] = 16'h2222;
        ld_pos[2] = 15; ld_din[2] = 16'h3333;
        run_frame(v0050, 4'b0000, 4'b1111);
        clear_loads();
        run_frame(v3333, 4'b0000, 4'b1111);

        // 5: async reset mid-slot 2 with a pending load
        ld_pos[0] = 2; ld_din[0] = 16'h9999;
        for (int i = 0; i < 10; i++) begin
            drive_loads(i);
            tick_check(v3333, 4'b0000, 4'b1111);
            load = 1'b0;
        end
        clear_loads();
        #2;
        rst = 1'b1;
        #1;
        check_dark("async_rst");
        @(negedge clk);
        rst = 1'b0;
        n   = 0;
        #1;
        check_dark("rst_release");
        run_frame(zeros, 4'b0000, 4'b1111);
        run_frame(zeros, 4'b0000, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
